// File: rtl/sat_counter_pkg.sv
// rtl/sat_counter_pkg.sv - shared limit-mode encodings and read-select width helper
package sat_counter_pkg;

    localparam int MODE_SAT  = 0;
    localparam int MODE_WRAP = 1;

    // A single channel still needs a 1-bit selector so the port never collapses to zero width.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/sat_counter_cell.sv
// rtl/sat_counter_cell.sv - one counter channel with limit handling and sticky limit flag
module sat_counter_cell
    import sat_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX   = (1 << WIDTH) - 1,
    parameter int WRAP  = MODE_SAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    input  logic             rd_clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             limit_hit
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic up;
    logic down;

    assign up      = inc & ~dec;
    assign down    = dec & ~inc;
    assign at_max  = (count == MAX_V);
    assign at_zero = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            limit_hit <= 1'b0;
        end else if (clr) begin
            count     <= '0;
            limit_hit <= 1'b0;
        end else if (rd_clr) begin
            // A coincident increment survives the read-clear so no event is lost.
            count <= {{(WIDTH-1){1'b0}}, up};
        end else if (up) begin
            if (at_max) begin
                limit_hit <= 1'b1;
                count     <= (WRAP == MODE_WRAP) ? '0 : MAX_V;
            end else begin
                count <= count + 1'b1;
            end
        end else if (down) begin
            if (at_zero) begin
                limit_hit <= 1'b1;
                count     <= (WRAP == MODE_WRAP) ? MAX_V : '0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sat_counter_bank.sv
// rtl/sat_counter_bank.sv - bank of independent limit counters with a registered read port
module sat_counter_bank
    import sat_counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int MAX    = (1 << WIDTH) - 1,
    parameter int WRAP   = MODE_SAT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           clr,
    input  logic [NUM_CH-1:0]           inc,
    input  logic [NUM_CH-1:0]           dec,
    input  logic                        rd_req,
    input  logic [ch_width(NUM_CH)-1:0] rd_ch,
    input  logic                        rd_clr,
    output logic                        rd_valid,
    output logic [WIDTH-1:0]            rd_data,
    output logic [NUM_CH*WIDTH-1:0]     count,
    output logic [NUM_CH-1:0]           at_max,
    output logic [NUM_CH-1:0]           at_zero,
    output logic [NUM_CH-1:0]           limit_hit
);

    localparam int CHW = ch_width(NUM_CH);

    logic [WIDTH-1:0] sel_count;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sat_counter_cell #(
            .WIDTH (WIDTH),
            .MAX   (MAX),
            .WRAP  (WRAP)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr[i]),
            .inc       (inc[i]),
            .dec       (dec[i]),
            .rd_clr    (rd_req && rd_clr && (rd_ch == CHW'(i))),
            .count     (count[i*WIDTH +: WIDTH]),
            .at_max    (at_max[i]),
            .at_zero   (at_zero[i]),
            .limit_hit (limit_hit[i])
        );
    end

    // Out-of-range selectors match no channel and therefore read back zero.
    always_comb begin
        sel_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CHW'(i)) begin
                sel_count = count[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= sel_count;
            end
        end
    end

endmodule

// File: doc/sat_counter_bank.md
SAT_COUNTER_BANK -- requirements
Module: sat_counter_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (>=2).
REQ-002 The block SHALL have parameter NUM_CH, default 4, number of independent channels (>=1).
REQ-003 The block SHALL have parameter MAX, default (1<<WIDTH)-1, upper count limit (1..2^WIDTH-1).
REQ-004 The block SHALL have parameter WRAP, default 0, limit behaviour: 0 = saturate, 1 = wrap.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset exists.
REQ-006 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port clr, input, NUM_CH, per-channel synchronous clear.
REQ-009 The block SHALL have port inc, input, NUM_CH, per-channel increment request.
REQ-010 The block SHALL have port dec, input, NUM_CH, per-channel decrement request.
REQ-011 The block SHALL have port rd_req, input, 1, read strobe.
REQ-012 The block SHALL have port rd_ch, input, max(1,$clog2(NUM_CH)), channel to read.
REQ-013 The block SHALL have port rd_clr, input, 1, clear-on-read qualifier for rd_req.
REQ-014 The block SHALL have port rd_valid, output, 1, read data valid pulse.
REQ-015 The block SHALL have port rd_data, output, WIDTH, read value.
REQ-016 The block SHALL have port count, output, NUM_CH*WIDTH, all counts; channel i in bits [i*WIDTH +: WIDTH].
REQ-017 The block SHALL have port at_max, output, NUM_CH, count == MAX (combinational from register).
REQ-018 The block SHALL have port at_zero, output, NUM_CH, count == 0 (combinational from register).
REQ-019 The block SHALL have port limit_hit, output, NUM_CH, sticky flag: limit reached by inc at MAX or dec at 0.

Function
REQ-020 Per channel, per rising edge, priority SHALL be: clr > read-clear > inc/dec.
REQ-021 clr=1: count <= 0 and limit_hit <= 0, regardless of inc/dec/read.
REQ-022 inc=1, dec=0, count<MAX: count <= count+1.
REQ-023 dec=1, inc=0, count>0: count <= count-1.
REQ-024 inc=1 and dec=1 together: count unchanged, limit_hit unchanged.
REQ-025 inc at count==MAX: WRAP=0 holds MAX; WRAP=1 loads 0; both set limit_hit.
REQ-026 dec at count==0: WRAP=0 holds 0; WRAP=1 loads MAX; both set limit_hit.
REQ-027 Read: rd_req=1 at edge N SHALL sample count[rd_ch] as held before edge N; rd_valid=1 and rd_data valid for exactly the cycle after edge N (latency 1).
REQ-028 rd_req=0 at an edge: rd_valid <= 0 and rd_data holds its last value.
REQ-029 rd_req=1, rd_clr=1, valid rd_ch, clr=0: that channel loads 1 if inc=1 and dec=0, else 0; limit_hit unchanged (no event lost).
REQ-030 rd_ch >= NUM_CH: rd_valid=1, rd_data=0, no channel affected.
REQ-031 Back-to-back rd_req SHALL be accepted every cycle; no busy state.
REQ-032 Counts SHALL never exceed MAX nor leave the 0..MAX range in either mode.

Reset
REQ-033 rst_n=0 SHALL asynchronously force all counts 0, limit_hit 0, rd_valid 0, rd_data 0; at_zero all 1, at_max all 0.
REQ-034 Reset assertion mid-read SHALL suppress the pending rd_valid; first edge after rst_n rises operates normally.

Structure
REQ-035 Shared package sat_counter_pkg SHALL hold the WRAP mode encodings (SAT=0, WRAP=1) and the rd_ch width function.
REQ-036 One sub-module, sat_counter_cell (one channel: count, limit_hit, at_max, at_zero), SHALL be instantiated NUM_CH times; read mux/register lives in the top.

Verification
REQ-037 WIDTH=4, MAX=9, WRAP=0: 12 inc pulses on ch0 -> count 9, at_max=1, limit_hit[0]=1 after the 10th pulse; other channels 0.
REQ-038 WRAP=1, MAX=9: count 9, inc -> 0; count 0, dec -> 9; limit_hit set each time.
REQ-039 ch1=5, rd_req, rd_ch=1, rd_clr=1, inc[1]=1 same edge -> next cycle rd_valid=1, rd_data=5, count[1]=1.
REQ-040 ch2=3, inc=dec=1 for 4 cycles -> count stays 3; clr[2] with inc[2] -> count 0, limit_hit 0.
REQ-041 NUM_CH=3, rd_ch=3 -> rd_valid=1, rd_data=0, all counts unchanged.
REQ-042 rst_n low asynchronously mid-count (ch0=7, rd_req pending) -> all outputs reset values immediately, rd_valid 0 after release.
